// File: rtl/det_2x2.sv
// det_2x2: complex 2x2 determinant det = a*d - b*c, signed Q4.12.
// One shared 16x16 multiplier, eight MAC cycles, one format cycle.
// Ports: clk, reset_n (async, active low), enable (clock enable),
//   accept_in/accept_out capture handshake, ready_out result pulse,
//   a_*..d_* complex inputs, det_re/det_im/singular registered result.
// Build option: DET_SATURATE_EN clamps the result, otherwise it wraps.
module det_2x2 #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             accept_in,
  output logic             accept_out,
  output logic             ready_out,
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  input  logic [WIDTH-1:0] b_re,
  input  logic [WIDTH-1:0] b_im,
  input  logic [WIDTH-1:0] c_re,
  input  logic [WIDTH-1:0] c_im,
  input  logic [WIDTH-1:0] d_re,
  input  logic [WIDTH-1:0] d_im,
  output logic [WIDTH-1:0] det_re,
  output logic [WIDTH-1:0] det_im,
  output logic             singular
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = PW + 2;

  localparam logic signed [AW-1:0] HALF =
    {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    FMT
  } state_t;

  state_t state;
  logic [2:0] k;

  logic signed [WIDTH-1:0] ar, ai, br, bi;
  logic signed [WIDTH-1:0] cr, ci, dr, di;
  logic signed [AW-1:0]    acc_re, acc_im;

  logic signed [WIDTH-1:0] op_x, op_y;
  logic                    neg;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    pext, term;

  logic signed [AW-1:0]    rnd_re, rnd_im;
  logic signed [AW-1:0]    sh_re, sh_im;
  logic [WIDTH-1:0]        red_re, red_im;
  logic                    red_zero;

  // Operand schedule: k0..k3 build the real part, k4..k7 the imag part.
  always_comb begin
    op_x = ar;
    op_y = dr;
    neg  = 1'b0;
    case (k)
      3'd0: begin op_x = ar; op_y = dr; neg = 1'b0; end
      3'd1: begin op_x = ai; op_y = di; neg = 1'b1; end
      3'd2: begin op_x = br; op_y = cr; neg = 1'b1; end
      3'd3: begin op_x = bi; op_y = ci; neg = 1'b0; end
      3'd4: begin op_x = ar; op_y = di; neg = 1'b0; end
      3'd5: begin op_x = ai; op_y = dr; neg = 1'b0; end
      3'd6: begin op_x = br; op_y = ci; neg = 1'b1; end
      default: begin op_x = bi; op_y = cr; neg = 1'b1; end
    endcase
  end

  always_comb begin
    prod = op_x * op_y;
    pext = {{2{prod[PW-1]}}, prod};
    term = neg ? -pext : pext;
  end

  // Round half up, then drop the fraction bits of the product.
  always_comb begin
    rnd_re = acc_re + HALF;
    rnd_im = acc_im + HALF;
    sh_re  = rnd_re >>> FRAC;
    sh_im  = rnd_im >>> FRAC;
  end

`ifdef DET_SATURATE_EN
  localparam logic signed [AW-1:0] MAXV =
    {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] POS_SAT = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_SAT = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    if (sh_re > MAXV)
      red_re = POS_SAT;
    else if (sh_re < MINV)
      red_re = NEG_SAT;
    else
      red_re = sh_re[WIDTH-1:0];
    if (sh_im > MAXV)
      red_im = POS_SAT;
    else if (sh_im < MINV)
      red_im = NEG_SAT;
    else
      red_im = sh_im[WIDTH-1:0];
  end
`else
  // Two's-complement wrap: the upper bits are simply discarded.
  logic unused_hi;
  assign unused_hi = ^{sh_re[AW-1:WIDTH], sh_im[AW-1:WIDTH]};

  always_comb begin
    red_re = sh_re[WIDTH-1:0];
    red_im = sh_im[WIDTH-1:0];
  end
`endif

  assign red_zero = (red_re == '0) && (red_im == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      k          <= '0;
      acc_re     <= '0;
      acc_im     <= '0;
      ar         <= '0;
      ai         <= '0;
      br         <= '0;
      bi         <= '0;
      cr         <= '0;
      ci         <= '0;
      dr         <= '0;
      di         <= '0;
      det_re     <= '0;
      det_im     <= '0;
      singular   <= 1'b0;
      accept_out <= 1'b0;
      ready_out  <= 1'b0;
    end else begin
      // Pulses drop on the next edge even when stalled.
      accept_out <= 1'b0;
      ready_out  <= 1'b0;
      if (enable) begin
        unique case (state)
          IDLE: begin
            if (accept_in) begin
              ar         <= a_re;
              ai         <= a_im;
              br         <= b_re;
              bi         <= b_im;
              cr         <= c_re;
              ci         <= c_im;
              dr         <= d_re;
              di         <= d_im;
              k          <= '0;
              acc_re     <= '0;
              acc_im     <= '0;
              accept_out <= 1'b1;
              state      <= MAC;
            end
          end
          MAC: begin
            if (k[2])
              acc_im <= acc_im + term;
            else
              acc_re <= acc_re + term;
            k <= k + 3'd1;
            if (k == 3'd7)
              state <= FMT;
          end
          FMT: begin
            det_re    <= red_re;
            det_im    <= red_im;
            singular  <= red_zero;
            ready_out <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_det_2x2.sv
// tb_det_2x2: randomized scoreboard bench for det_2x2.
// Driver pushes model results on capture; monitor pops on ready_out.
module tb_det_2x2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        accept_in = 1'b0;
  logic        accept_out, ready_out, singular;
  logic [15:0] a_re, a_im, b_re, b_im;
  logic [15:0] c_re, c_im, d_re, d_im;
  logic [15:0] det_re, det_im;

  det_2x2 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .accept_in (accept_in),
    .accept_out(accept_out),
    .ready_out (ready_out),
    .a_re      (a_re),
    .a_im      (a_im),
    .b_re      (b_re),
    .b_im      (b_im),
    .c_re      (c_re),
    .c_im      (c_im),
    .d_re      (d_re),
    .d_im      (d_im),
    .det_re    (det_re),
    .det_im    (det_im),
    .singular  (singular)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic        sing;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     fails = 0;
  longint edge_cnt = 0;
  longint cap_mark = 0;
  bit     prev_acc = 0;
  bit     prev_rdy = 0;
  bit     jitter = 0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] reduce(input longint v);
    logic [15:0] w;
`ifdef DET_SATURATE_EN
    if (v > 32767)
      w = 16'h7FFF;
    else if (v < -32768)
      w = 16'h8000;
    else
      w = v[15:0];
`else
    w = v[15:0];
`endif
    return w;
  endfunction

  // Complex arithmetic straight from det = a*d - b*c.
  function automatic exp_t model(
    input logic signed [15:0] ar, ai, br, bi,
    input logic signed [15:0] cr, ci, dr, di);
    longint re, im;
    exp_t   e;
    re = (longint'(ar) * longint'(dr) - longint'(ai) * longint'(di))
       - (longint'(br) * longint'(cr) - longint'(bi) * longint'(ci));
    im = (longint'(ar) * longint'(di) + longint'(ai) * longint'(dr))
       - (longint'(br) * longint'(ci) + longint'(bi) * longint'(cr));
    re = (re + 2048) >>> 12;
    im = (im + 2048) >>> 12;
    e.re   = reduce(re);
    e.im   = reduce(im);
    e.sing = (e.re == 16'h0) && (e.im == 16'h0);
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (jitter)
      enable = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(
    input logic [15:0] ar, ai, br, bi, cr, ci, dr, di,
    input bit hold, output int waited);
    bit got;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    c_re = cr; c_im = ci; d_re = dr; d_im = di;
    accept_in = 1'b1;
    waited = 0;
    got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      tick();
      waited++;
      if (accept_out)
        got = 1;
    end
    if (got) begin
      sb.push_back(model(ar, ai, br, bi, cr, ci, dr, di));
      if (!hold) begin
        accept_in = 1'b0;
        // Garbage on the buses while busy must be ignored.
        a_re = 16'($urandom); d_re = 16'($urandom);
        b_im = 16'($urandom); c_im = 16'($urandom);
      end
    end else begin
      chk("capture_timeout", 0, 1);
      accept_in = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++)
      tick();
    chk("drain_empty", sb.size(), 0);
  endtask

  always @(posedge clk)
    if (reset_n && enable)
      edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (accept_out) begin
        chk("accept_pulse_width", prev_acc, 0);
        cap_mark = edge_cnt;
      end
      if (ready_out) begin
        chk("ready_pulse_width", prev_rdy, 0);
        if (sb.size() == 0) begin
          chk("unexpected_ready", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("det_re", det_re, e.re);
          chk("det_im", det_im, e.im);
          chk("singular", singular, e.sing);
          chk("latency", edge_cnt - cap_mark, 9);
        end
      end
    end
    prev_acc = accept_out;
    prev_rdy = ready_out;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    bit done;
    logic [15:0] v[8];
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    c_re = '0; c_im = '0; d_re = '0; d_im = '0;
    repeat (3) @(negedge clk);
    chk("reset_det_re", det_re, 0);
    chk("reset_det_im", det_im, 0);
    chk("reset_singular", singular, 0);
    chk("reset_accept_out", accept_out, 0);
    chk("reset_ready_out", ready_out, 0);
    reset_n = 1'b1;
    enable = 1'b1;
    tick();

    // Directed: identity, real, j*j, all ones, overflow.
    send(16'h1000, 0, 0, 0, 0, 0, 16'h1000, 0, 0, w);
    send(16'h2000, 0, 16'h1000, 0, 16'h4000, 0, 16'h3000, 0, 0, w);
    send(0, 16'h1000, 0, 0, 0, 0, 0, 16'h1000, 0, w);
    send(16'h1000, 0, 16'h1000, 0, 16'h1000, 0, 16'h1000, 0, 0, w);
    send(16'h4000, 0, 0, 0, 0, 0, 16'h4000, 0, 0, w);
    drain();

    // accept_in held high: captures every 10 cycles.
    send(16'h0800, 16'h0100, 16'h0200, 0, 16'hF000, 0, 16'h1800, 0, 1, w);
    send(16'h1234, 16'hFEDC, 16'h0321, 16'h0456, 16'hF111, 16'h0222,
         16'h0333, 16'hFF44, 1, w);
    chk("throughput_gap", w, 10);
    send(16'h2000, 0, 0, 16'h1000, 0, 16'h1000, 16'h2000, 0, 0, w);
    chk("throughput_gap2", w, 10);
    drain();

    // Three stalled cycles in the middle of MAC.
    tick();
    send(16'h1800, 16'h0400, 16'hFC00, 16'h0200, 16'h0600, 16'hF800,
         16'h0A00, 16'h0300, 0, w);
    n = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      n++;
      if (n == 3) enable = 1'b0;
      if (n == 6) enable = 1'b1;
      if (ready_out) done = 1;
    end
    chk("stall_latency", n, 12);
    enable = 1'b1;
    drain();

    // Reset while MAC is at k=4: outputs clear, result discarded.
    send(16'h2000, 0, 16'h1000, 0, 16'h4000, 0, 16'h3000, 0, 0, w);
    drain();
    send(16'h1000, 0, 0, 0, 0, 0, 16'h1000, 0, 0, w);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("midreset_det_re", det_re, 0);
    chk("midreset_det_im", det_im, 0);
    chk("midreset_singular", singular, 0);
    chk("midreset_ready_out", ready_out, 0);
    chk("midreset_accept_out", accept_out, 0);
    if (sb.size() != 0)
      void'(sb.pop_back());
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (12) tick();
    send(16'h0C00, 16'h0400, 16'h0200, 16'hFE00, 16'h0100, 16'h0300,
         16'h1000, 16'hF800, 0, w);
    drain();

    // Random matrices with random enable stalls.
    jitter = 1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 8; i++) begin
        if (t % 3 == 0)
          v[i] = 16'($urandom);
        else
          v[i] = 16'($urandom_range(0, 16384)) - 16'd8192;
      end
      send(v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7], 0, w);
    end
    drain();
    jitter = 0;
    enable = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
